// File: rtl/mag_cmp_pkg.sv
// Shared constants and helpers for the pipelined magnitude comparator.
package mag_cmp_pkg;

    localparam int DEFAULT_N = 10;
    localparam int DEFAULT_G = 4;

    function automatic int group_count(input int n, input int g);
        return (n + g - 1) / g;
    endfunction

endpackage

// File: rtl/mag_cmp_group.sv
// Combinational unsigned compare of one G-bit slice of A and B.
module mag_cmp_group #(
    parameter int G = 4
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    output logic         gt,
    output logic         lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/n_bit_magnitude_comparator.sv
// Two-stage pipelined unsigned magnitude comparator: per-group flags are registered first,
// then reduced most-significant-group-first into a registered one-hot result.
module n_bit_magnitude_comparator
    import mag_cmp_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int G = DEFAULT_G
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         L_T,
    output logic         G_T,
    output logic         E,
    output logic         out_valid
);

    localparam int NG = group_count(N, G);
    localparam int PW = NG * G;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [NG-1:0] grp_gt;
    logic [NG-1:0] grp_lt;
    logic [NG-1:0] gt_q;
    logic [NG-1:0] lt_q;
    logic          valid_q;
    logic          gt_c;
    logic          lt_c;

    // Zero padding lands equally on both operands, so the top group compares only real bits.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[N-1:0] = A;
        b_ext[N-1:0] = B;
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        mag_cmp_group #(.G(G)) u_grp (
            .a  (a_ext[gi*G +: G]),
            .b  (b_ext[gi*G +: G]),
            .gt (grp_gt[gi]),
            .lt (grp_lt[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q    <= '0;
            lt_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                gt_q <= grp_gt;
                lt_q <= grp_lt;
            end
        end
    end

    // Walking upward and overwriting leaves the most significant unequal group in charge.
    always_comb begin
        gt_c = 1'b0;
        lt_c = 1'b0;
        for (int i = 0; i < NG; i++) begin
            if (gt_q[i] || lt_q[i]) begin
                gt_c = gt_q[i];
                lt_c = lt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            L_T       <= 1'b0;
            G_T       <= 1'b0;
            E         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid_q;
            if (valid_q) begin
                L_T <= lt_c;
                G_T <= gt_c;
                E   <= ~(lt_c | gt_c);
            end
        end
    end

endmodule

// File: tb/tb_n_bit_magnitude_comparator.sv
// Bench for the comparator at N=10/G=4 and N=7/G=3: directed tables, hand sequences, random vs model.
module tb_n_bit_magnitude_comparator;

    localparam int N1 = 10;
    localparam int G1 = 4;
    localparam int N2 = 7;
    localparam int G2 = 3;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  res;
    } vec_t;

    typedef struct {
        logic        v;
        logic [63:0] a;
        logic [63:0] b;
    } stg_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v1;
    logic [N1-1:0] a1;
    logic [N1-1:0] b1;
    logic          lt1, gt1, e1, ov1;
    logic          v2;
    logic [N2-1:0] a2;
    logic [N2-1:0] b2;
    logic          lt2, gt2, e2, ov2;

    int errors = 0;
    int checks = 0;

    vec_t t10[13];
    vec_t t7[10];
    stg_t cur[2];
    stg_t p1[2];
    stg_t p2[2];
    logic [2:0] held[2];

    always #5 clk = ~clk;

    n_bit_magnitude_comparator #(.N(N1), .G(G1)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .A         (a1),
        .B         (b1),
        .L_T       (lt1),
        .G_T       (gt1),
        .E         (e1),
        .out_valid (ov1)
    );

    n_bit_magnitude_comparator #(.N(N2), .G(G2)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v2),
        .A         (a2),
        .B         (b2),
        .L_T       (lt2),
        .G_T       (gt2),
        .E         (e2),
        .out_valid (ov2)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ov/lt/gt/e=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_cmp(input logic [63:0] a, input logic [63:0] b);
        if (a < b) return LT;
        if (a > b) return GT;
        return EQ;
    endfunction

    function automatic logic [3:0] out10();
        return {ov1, lt1, gt1, e1};
    endfunction

    function automatic logic [3:0] out7();
        return {ov2, lt2, gt2, e2};
    endfunction

    initial begin
        logic [3:0]  act;
        logic [63:0] mask;
        int unsigned w;
        int unsigned mode;

        t10[0]  = '{64'd60,   64'd61,   LT};
        t10[1]  = '{64'd42,   64'd42,   EQ};
        t10[2]  = '{64'd63,   64'd39,   GT};
        t10[3]  = '{64'd0,    64'd1023, LT};
        t10[4]  = '{64'd1023, 64'd0,    GT};
        t10[5]  = '{64'd512,  64'd512,  EQ};
        t10[6]  = '{64'd512,  64'd513,  LT};
        t10[7]  = '{64'd0,    64'd0,    EQ};
        t10[8]  = '{64'd1,    64'd0,    GT};
        t10[9]  = '{64'd0,    64'd1,    LT};
        t10[10] = '{64'd512,  64'd0,    GT};
        t10[11] = '{64'd0,    64'd512,  LT};
        t10[12] = '{64'd3,    64'd515,  LT};

        t7[0] = '{64'd64,  64'd0,   GT};
        t7[1] = '{64'd0,   64'd64,  LT};
        t7[2] = '{64'd127, 64'd0,   GT};
        t7[3] = '{64'd0,   64'd127, LT};
        t7[4] = '{64'd1,   64'd0,   GT};
        t7[5] = '{64'd0,   64'd0,   EQ};
        t7[6] = '{64'd127, 64'd127, EQ};
        t7[7] = '{64'd65,  64'd64,  GT};
        t7[8] = '{64'd64,  64'd65,  LT};
        t7[9] = '{64'd8,   64'd7,   GT};

        rst_n = 1'b0;
        v1 = 1'b0; a1 = '0; b1 = '0;
        v2 = 1'b0; a2 = '0; b2 = '0;
        step();
        check("reset_n10", out10(), 4'b0000);
        check("reset_n7", out7(), 4'b0000);
        step();
        rst_n = 1'b1;

        // Back-to-back table streams; output of vector i-1 appears after vector i is captured.
        for (int i = 0; i <= 13; i++) begin
            if (i < 13) begin
                v1 = 1'b1; a1 = t10[i].a[N1-1:0]; b1 = t10[i].b[N1-1:0];
            end else begin
                v1 = 1'b0;
            end
            step();
            if (i >= 1) check($sformatf("tab10_%0d", i - 1), out10(), {1'b1, t10[i-1].res});
        end
        step();
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                v2 = 1'b1; a2 = t7[i].a[N2-1:0]; b2 = t7[i].b[N2-1:0];
            end else begin
                v2 = 1'b0;
            end
            step();
            if (i >= 1) check($sformatf("tab7_%0d", i - 1), out7(), {1'b1, t7[i-1].res});
        end
        step();

        // Single valid then idle: one out_valid pulse, result held afterwards.
        v1 = 1'b1; a1 = 10'd100; b1 = 10'd200;
        step();
        v1 = 1'b0;
        check("pulse_c1", out10(), {1'b0, t10[12].res});
        step();
        check("pulse_c2", out10(), {1'b1, LT});
        step();
        check("pulse_c3", out10(), {1'b0, LT});
        step();
        check("pulse_c4", out10(), {1'b0, LT});

        // Reset with compares in flight.
        v1 = 1'b1; a1 = 10'd9; b1 = 10'd2;
        step();
        a1 = 10'd2; b1 = 10'd9;
        step();
        check("pre_rst", out10(), {1'b1, GT});
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", out10(), 4'b0000);
        v1 = 1'b0;
        step();
        check("rst_hold", out10(), 4'b0000);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_1", out10(), 4'b0000);
        step();
        check("post_rst_2", out10(), 4'b0000);
        v1 = 1'b1; a1 = 10'd7; b1 = 10'd7;
        step();
        v1 = 1'b0;
        check("first_c1", out10(), 4'b0000);
        step();
        check("first_c2", out10(), {1'b1, EQ});

        // Random phase against a transaction-level model.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            p1[d] = '{1'b0, 64'd0, 64'd0};
            p2[d] = '{1'b0, 64'd0, 64'd0};
            held[d] = 3'b000;
        end
        for (int n = 0; n < 10000; n++) begin
            for (int d = 0; d < 2; d++) begin
                w = (d == 0) ? N1 : N2;
                mask = (64'd1 << w) - 64'd1;
                mode = $urandom_range(0, 7);
                cur[d].v = ($urandom_range(0, 9) < 8);
                cur[d].a = {$urandom, $urandom} & mask;
                cur[d].b = {$urandom, $urandom} & mask;
                case (mode)
                    0: cur[d].b = cur[d].a;
                    1: cur[d].a = mask;
                    2: cur[d].a = 64'd0;
                    3: cur[d].b = cur[d].a ^ (64'd1 << $urandom_range(0, w - 1));
                    default: ;
                endcase
            end
            v1 = cur[0].v; a1 = cur[0].a[N1-1:0]; b1 = cur[0].b[N1-1:0];
            v2 = cur[1].v; a2 = cur[1].a[N2-1:0]; b2 = cur[1].b[N2-1:0];
            step();
            for (int d = 0; d < 2; d++) begin
                p2[d] = p1[d];
                p1[d] = cur[d];
                if (p2[d].v) held[d] = ref_cmp(p2[d].a, p2[d].b);
                act = (d == 0) ? out10() : out7();
                check((d == 0) ? "rand_n10" : "rand_n7", act, {p2[d].v, held[d]});
                if (act[3]) check("onehot", {3'b000, $onehot(act[2:0])}, 4'b0001);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
